// File: rtl/leaf_output_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_output_arbiter
//
// Shares the leaf's single user-to-interface output port between NUM_REQ
// user-side producers. A burst-limited round-robin picks one producer per
// cycle; its beat is registered into a one-entry output stage together with
// the producer index. Everything runs in the user clock domain.
//
// Ports:
//   clk_user   in   user clock
//   reset_n    in   asynchronous active-low reset
//   din_req    in   producer payloads, producer i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   vld_req    in   producer i has a beat
//   ack_req    out  one-hot, producer i's beat is consumed this cycle
//   dout_leaf  out  registered beat towards the leaf interface
//   vld_leaf   out  dout_leaf valid
//   ack_leaf   in   leaf interface accepts dout_leaf this cycle
//   src_idx    out  producer index of the current dout_leaf beat
// -----------------------------------------------------------------------------
module leaf_output_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned IDX_BITS     = 2,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned BURST_BITS   = 4
) (
  input  logic                            clk_user,
  input  logic                            reset_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
  input  logic [NUM_REQ-1:0]              vld_req,
  output logic [NUM_REQ-1:0]              ack_req,
  output logic [PAYLOAD_BITS-1:0]         dout_leaf,
  output logic                            vld_leaf,
  input  logic                            ack_leaf,
  output logic [IDX_BITS-1:0]             src_idx
);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  localparam logic [BURST_BITS-1:0] MaxBurst = BURST_BITS'(MAX_BURST);
  localparam logic [IDX_BITS-1:0]   LastInit = IDX_BITS'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [IDX_BITS-1:0]     holder_q, holder_d;
  logic [IDX_BITS-1:0]     last_q, last_d;
  logic [BURST_BITS-1:0]   burst_q, burst_d;

  logic                    vld_leaf_q;
  logic [PAYLOAD_BITS-1:0] dout_leaf_q;
  logic [IDX_BITS-1:0]     src_idx_q;

  logic                    sel_valid;
  logic                    load;
  logic                    stall;
  logic                    keep_holder;
  logic [IDX_BITS-1:0]     rr_base;
  logic [IDX_BITS-1:0]     rr_winner;
  logic [IDX_BITS-1:0]     winner;
  logic [NUM_REQ-1:0]      grant_oh;
  logic [PAYLOAD_BITS-1:0] win_payload;

  assign sel_valid = |vld_req;
  assign stall     = vld_leaf_q && !ack_leaf;
  // ack_leaf enters through one OR gate only; the winner does not depend on it.
  assign load      = (!vld_leaf_q || ack_leaf) && sel_valid;

  assign keep_holder = (state_q == S_LOCKED) && vld_req[holder_q] && (burst_q < MaxBurst);
  assign rr_base     = (state_q == S_IDLE) ? last_q : holder_q;

  // Scan base+1 .. base+NUM_REQ; the base itself comes last, so a released
  // holder wins again only when it is the sole requester.
  always_comb begin
    logic                found;
    logic [IDX_BITS-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    rr_winner = rr_base;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_BITS'((int'(rr_base) + off) % NUM_REQ);
      if (!found && vld_req[cand]) begin
        found     = 1'b1;
        rr_winner = cand;
      end
    end
  end

  assign winner = keep_holder ? holder_q : rr_winner;

  always_comb begin
    grant_oh    = '0;
    win_payload = din_req[0 +: PAYLOAD_BITS];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_BITS'(i)) begin
        grant_oh[i] = 1'b1;
        win_payload = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // A beat loaded during reset would be dropped, so no ack may be given.
  assign ack_req = (load && reset_n) ? grant_oh : '0;

  always_comb begin
    state_d  = state_q;
    holder_d = holder_q;
    burst_d  = burst_q;
    last_d   = last_q;
    if (load) begin
      if (keep_holder) begin
        burst_d = burst_q + BURST_BITS'(1);
      end else begin
        if (state_q == S_LOCKED) begin
          last_d = holder_q;
        end
        state_d  = S_LOCKED;
        holder_d = winner;
        burst_d  = BURST_BITS'(1);
      end
    end else if (!stall && (state_q == S_LOCKED)) begin
      // Not stalled and not loading means nobody is requesting.
      last_d  = holder_q;
      state_d = S_IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      holder_q    <= '0;
      burst_q     <= '0;
      last_q      <= LastInit;
      vld_leaf_q  <= 1'b0;
      dout_leaf_q <= '0;
      src_idx_q   <= '0;
    end else begin
      state_q  <= state_d;
      holder_q <= holder_d;
      burst_q  <= burst_d;
      last_q   <= last_d;
      if (load) begin
        vld_leaf_q  <= 1'b1;
        dout_leaf_q <= win_payload;
        src_idx_q   <= winner;
      end else if (ack_leaf && vld_leaf_q) begin
        vld_leaf_q <= 1'b0;
      end
    end
  end

  assign vld_leaf  = vld_leaf_q;
  assign dout_leaf = dout_leaf_q;
  assign src_idx   = src_idx_q;

endmodule

// File: doc/leaf_output_arbiter.md
# leaf_output_arbiter

Round-robin arbiter that shares the single user-to-interface output port of a leaf between `NUM_REQ` user-side producers. Each producer presents 32-bit payload beats with a vld/ack handshake; the block registers one winning beat per cycle and presents it, with its source index, to the leaf interface's `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` port. It sits inside the leaf wrapper, between the user kernel's output streams and the leaf interface, all in the user clock domain.

## Interface
- `NUM_REQ`, 4, number of producers sharing the port (2..16)
- `PAYLOAD_BITS`, 32, beat width
- `IDX_BITS`, 2, width of source index; must be ≥ clog2(`NUM_REQ`)
- `MAX_BURST`, 8, max consecutive beats granted to one producer before forced rotation (1..2^`BURST_BITS`-1)
- `BURST_BITS`, 4, burst counter width

Ports:
- `clk_user`  in  1  user clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `din_req`  in  `NUM_REQ`*`PAYLOAD_BITS`  producer payloads, producer i at bits [i*`PAYLOAD_BITS` +: `PAYLOAD_BITS`]
- `vld_req`  in  `NUM_REQ`  producer i has a beat
- `ack_req`  out  `NUM_REQ`  one-hot; producer i's beat is consumed this cycle
- `dout_leaf`  out  `PAYLOAD_BITS`  registered beat to leaf interface
- `vld_leaf`  out  1  `dout_leaf` valid
- `ack_leaf`  in  1  leaf interface accepts `dout_leaf` this cycle
- `src_idx`  out  `IDX_BITS`  producer index of the current `dout_leaf` beat

## Operation
- Handshake on both sides: a transfer occurs on a rising edge where vld and ack are both 1. Producers hold payload and vld stable until acked. `vld_leaf`/`dout_leaf`/`src_idx` stay stable until `ack_leaf`.
- Output register: one-entry. `load = (!vld_leaf || ack_leaf) && sel_valid`. On load: `dout_leaf` ← winner's payload, `src_idx` ← winner, `vld_leaf` ← 1. If `ack_leaf && vld_leaf && !load`: `vld_leaf` ← 0. `dout_leaf` holds its last value when not loading.
- `ack_req` is combinational: `ack_req[w] = load` for winner w, all other bits 0. At most one bit is ever set.
- States:
  - IDLE: no holder. Winner = first i with `vld_req[i]`, scanning from `last+1` modulo `NUM_REQ`. On load: go to LOCKED, holder ← winner, `burst_cnt` ← 1.
  - LOCKED: if `vld_req[holder]` and `burst_cnt < MAX_BURST`, the winner is the holder. On load: `burst_cnt` +1.
  - LOCKED, holder drops vld or `burst_cnt == MAX_BURST`: round-robin from `holder+1`. The holder itself is eligible only if it is the sole requester. On load: holder ← new winner, `burst_cnt` ← 1. If no requester: go to IDLE.
  - `last` ← holder whenever a holder is released.
- `sel_valid = |vld_req`. No load when `vld_req == 0`. A stalled output (`vld_leaf && !ack_leaf`) blocks all loads and freezes state, `burst_cnt` and `last`.
- `burst_cnt` never exceeds `MAX_BURST`. With `MAX_BURST` = 1 the arbiter is pure round-robin.
- An `ack_leaf` received while `vld_leaf` = 0 is ignored.

## Timing
- Reset (async assert, sync-safe release): `vld_leaf`=0, `dout_leaf`=0, `src_idx`=0, state=IDLE, `burst_cnt`=0, `last`=`NUM_REQ`-1 (so producer 0 has first priority). `ack_req`=0 while reset is asserted.
- Latency: a producer beat acked at edge k appears on `vld_leaf` after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle while `ack_leaf` is held high; simultaneous accept and reload in the same cycle is required.
- `ack_req` depends combinationally on `vld_req` and `ack_leaf`. The path through `ack_leaf` must be single-level.
- Reset asserted mid-transfer drops the registered beat. Producers see no ack for it and retain their beat.

## Test plan
- Reset, then `vld_req`=4'b0001 with `din_req[0]`=0xA5A5_0001, `ack_leaf`=1 → `ack_req`=0001 in cycle 0; `vld_leaf`=1, `dout_leaf`=0xA5A5_0001, `src_idx`=0 in cycle 1.
- All four producers valid continuously, `ack_leaf`=1, `MAX_BURST`=8 → `src_idx` sequence is 0×8, 1×8, 2×8, 3×8, 0…, with no idle cycles.
- Producers 1 and 3 valid, producer 1 drops vld after 3 beats → beats 1,1,1 then 3; next rotation starts at producer 0 and picks 1 if it is valid.
- `vld_leaf`=1 with `ack_leaf`=0 for 5 cycles while all producers are valid → `ack_req`=0 and `dout_leaf`/`src_idx` stable throughout; one beat is loaded on the first cycle `ack_leaf`=1.
- Single requester 2 valid for 20 beats, `MAX_BURST`=8 → 20 consecutive beats from 2 with no bubbles at the burst boundaries.
- Assert `reset_n`=0 while `vld_leaf`=1 → `vld_leaf`=0 immediately. After release, the first grant goes to producer 0 if it is valid.
